// File: rtl/rr_packet_mux.sv
// Packet-level round-robin multiplexer: shares one registered output link
// between NUM_REQ valid/ready flit streams. A grant is locked from the first
// flit until the granted stream's last flit is accepted. When arb_enable is
// low, the stream named by single_sel is served instead of round-robin.
`timescale 1ns/1ps

module rr_packet_mux #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      arb_enable,
   input  logic [NUM_REQ-1:0]        single_sel,
   input  logic [NUM_REQ-1:0]        in_valid,
   input  logic [NUM_REQ*DATA_W-1:0] in_data,
   input  logic [NUM_REQ-1:0]        in_last,
   output logic [NUM_REQ-1:0]        in_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_last,
   input  logic                      out_ready,
   output logic [NUM_REQ-1:0]        cur_grant,
   output logic                      busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state, state_nx;
   logic [IDX_W-1:0]   ptr, ptr_nx;
   logic [IDX_W-1:0]   gnt_idx, gnt_idx_nx;
   logic [NUM_REQ-1:0] grant_nx;
   logic               rr_mode, rr_mode_nx;

   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   cand;
   logic [IDX_W-1:0]   fixed_idx;

   logic               xfer;
   logic               sel_last;
   logic [DATA_W-1:0]  sel_data;

   // Pick the stream that wins the next packet grant (round-robin or fixed).
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // through the block leaves it unassigned and no latch is inferred.
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      fixed_idx = '0;
      if (arb_enable) begin
         // Search ptr, ptr+1, ... cyclically; the first valid stream wins.
         for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!win_found && in_valid[cand]) begin
               win_found = 1'b1;
               win_idx   = cand;
            end
         end
      end else begin
         // Lowest set bit of single_sel names the channel; it must be valid.
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (single_sel[i]) fixed_idx = IDX_W'(i);
         end
         win_found = (|single_sel) && in_valid[fixed_idx];
         win_idx   = fixed_idx;
      end
   end

   // Only the granted stream sees ready, and only when the output slot frees.
   assign in_ready = (state == BUSY) ? (cur_grant & {NUM_REQ{out_ready | ~out_valid}})
                                     : '0;
   assign xfer     = |(in_valid & in_ready);
   assign sel_last = |(in_last & cur_grant);
   assign busy     = (state == BUSY);

   // One-hot data select for the granted stream.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (cur_grant[i]) sel_data = in_data[i*DATA_W +: DATA_W];
      end
   end

   // Next-state logic: lock a grant in IDLE, release it on the last flit.
   always_comb begin
      state_nx   = state;
      grant_nx   = cur_grant;
      gnt_idx_nx = gnt_idx;
      ptr_nx     = ptr;
      rr_mode_nx = rr_mode;
      case (state)
         IDLE: begin
            if (win_found) begin
               state_nx   = BUSY;
               grant_nx   = NUM_REQ'(1) << win_idx;
               gnt_idx_nx = win_idx;
               // Mode is latched so mid-packet arb_enable changes are ignored.
               rr_mode_nx = arb_enable;
            end
         end
         BUSY: begin
            if (xfer && sel_last) begin
               state_nx = IDLE;
               grant_nx = '0;
               if (rr_mode) begin
                  ptr_nx = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
               end
            end
         end
      endcase
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         cur_grant <= '0;
         gnt_idx   <= '0;
         rr_mode   <= 1'b0;
      end else begin
         state     <= state_nx;
         ptr       <= ptr_nx;
         cur_grant <= grant_nx;
         gnt_idx   <= gnt_idx_nx;
         rr_mode   <= rr_mode_nx;
      end
   end

   // Output register: load on transfer, drain on out_ready, otherwise hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the data/last registers are reset too because downstream
         // observes them as defined zeros after reset, not just out_valid.
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_last  <= sel_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_packet_mux.sv
// Self-checking bench for rr_packet_mux: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model
// with a scoreboard of expected output flits.
`timescale 1ns/1ps

module tb_rr_packet_mux;

   localparam int N = 4;
   localparam int W = 64;

   typedef struct packed {
      logic [W-1:0] data;
      logic         last;
   } flit_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           arb_enable;
   logic [N-1:0]   single_sel;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_last;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic           out_last;
   logic           out_ready;
   logic [N-1:0]   cur_grant;
   logic           busy;

   rr_packet_mux #(.NUM_REQ(N), .DATA_W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .arb_enable (arb_enable),
      .single_sel (single_sel),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .cur_grant  (cur_grant),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Upstream packet sources and the scoreboard of expected output flits.
   flit_t src_q [N][$];
   flit_t sb_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: which stream holds the link, priority start, and
   // whether the output slot holds an undelivered flit.
   int m_lock = -1;
   int m_ptr  = 0;
   bit m_rr   = 1'b0;
   bit m_full = 1'b0;

   int           glog[$];
   logic [N-1:0] prev_grant = '0;
   bit           prev_hold  = 1'b0;
   flit_t        prev_out;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   // Winner of a new packet, straight from the arbitration rules.
   function automatic int pick_winner(input logic arb, input logic [N-1:0] sel,
                                      input logic [N-1:0] iv);
      if (arb) begin
         for (int k = 0; k < N; k++) begin
            if (iv[(m_ptr + k) % N]) return (m_ptr + k) % N;
         end
         return -1;
      end
      for (int i = 0; i < N; i++) begin
         if (sel[i]) return iv[i] ? i : -1;
      end
      return -1;
   endfunction

   task automatic load(input int s, input int len, input logic [W-1:0] base);
      for (int k = 0; k < len; k++) begin
         src_q[s].push_back('{data: base + W'(k), last: (k == len - 1)});
      end
   endtask

   task automatic load_rand(input int s, input int len);
      for (int k = 0; k < len; k++) begin
         src_q[s].push_back('{data: {$urandom, $urandom}, last: (k == len - 1)});
      end
   endtask

   task automatic clear_sources();
      for (int i = 0; i < N; i++) src_q[i].delete();
   endtask

   // One clock cycle: check state, drive inputs, check ready, advance model.
   task automatic step(input logic r, input logic arb, input logic [N-1:0] sel,
                       input logic [N-1:0] vmask, input logic ordy);
      logic [N-1:0] exp_rdy;
      int           w;
      @(negedge clk);
      check("cur_grant", cur_grant, onehot(m_lock));
      check("busy", busy, m_lock >= 0);
      check("out_valid", out_valid, m_full);
      if (prev_hold) begin
         check("hold_data", out_data, prev_out.data);
         check("hold_last", out_last, prev_out.last);
      end
      if (cur_grant != '0 && prev_grant == '0) begin
         for (int i = 0; i < N; i++) if (cur_grant[i]) glog.push_back(i);
      end
      prev_grant = cur_grant;

      rst        = r;
      arb_enable = arb;
      single_sel = sel;
      out_ready  = ordy;
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() > 0) begin
            in_valid[i]         = vmask[i];
            in_data[i*W +: W]   = src_q[i][0].data;
            in_last[i]          = src_q[i][0].last;
         end else begin
            in_valid[i]         = 1'b0;
            in_data[i*W +: W]   = {$urandom, $urandom};
            in_last[i]          = 1'($urandom);
         end
      end
      prev_hold = out_valid && !ordy && !r;
      prev_out  = '{data: out_data, last: out_last};

      #1;
      exp_rdy = '0;
      if (m_lock >= 0 && (ordy || !m_full)) exp_rdy[m_lock] = 1'b1;
      check("in_ready", in_ready, exp_rdy);

      // Upstream reacts to the observed handshake.
      for (int i = 0; i < N; i++) begin
         if (!r && in_valid[i] && in_ready[i]) void'(src_q[i].pop_front());
      end

      if (r) begin
         m_lock = -1;
         m_ptr  = 0;
         m_full = 1'b0;
         sb_q.delete();
         clear_sources();
         prev_hold = 1'b0;
      end else if (m_lock < 0) begin
         w = pick_winner(arb, sel, in_valid);
         if (ordy) m_full = 1'b0;
         if (w >= 0) begin
            m_lock = w;
            m_rr   = arb;
         end
      end else if (in_valid[m_lock] && exp_rdy[m_lock]) begin
         for (int i = 0; i < N; i++) begin
            if (i == m_lock) sb_q.push_back('{data: in_data[i*W +: W], last: in_last[i]});
         end
         m_full = 1'b1;
         if (in_last[m_lock]) begin
            if (m_rr) m_ptr = (m_lock + 1) % N;
            m_lock = -1;
         end
      end else if (ordy) begin
         m_full = 1'b0;
      end
   endtask

   function automatic int glog_at(input int k);
      return (glog.size() > k) ? glog[k] : -1;
   endfunction

   // Monitor: every flit the downstream accepts must match the scoreboard.
   initial begin
      flit_t exp_f;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_underflow: got flit %0h with none expected at %0t", out_data, $time);
            end else begin
               exp_f = sb_q.pop_front();
               check("out_data", out_data, exp_f.data);
               check("out_last", out_last, exp_f.last);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] sel_r;
      logic [N-1:0] vm;
      logic         arb_r;

      arb_enable = 1'b1;
      single_sel = '0;
      in_valid   = '0;
      in_data    = '0;
      in_last    = '0;
      out_ready  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_data", out_data, '0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_in_ready", in_ready, '0);

      // All four streams requesting single-flit packets: grants 0,1,2,3,0.
      for (int i = 0; i < N; i++) load(i, 1, 64'hD0 + 64'(i));
      load(0, 1, 64'hD4);
      repeat (10) step(1'b0, 1'b1, '0, '1, 1'b1);
      for (int k = 0; k < 5; k++) check("rr_order", 64'(glog_at(k)), 64'(k % N));
      glog.delete();

      // Stream 1 three-flit packet with streams 0,2,3 waiting; ptr is 1.
      load(1, 3, 64'hA1);
      load(0, 1, 64'hB0);
      load(2, 1, 64'hB2);
      load(3, 1, 64'hB3);
      repeat (12) step(1'b0, 1'b1, '0, '1, 1'b1);
      check("pkt_grant_first", 64'(glog_at(0)), 64'd1);
      check("pkt_grant_next", 64'(glog_at(1)), 64'd2);
      glog.delete();

      // Backpressure: out_ready low for 4 cycles mid-packet.
      load(0, 6, 64'hE0);
      repeat (3) step(1'b0, 1'b1, '0, '1, 1'b1);
      repeat (4) step(1'b0, 1'b1, '0, '1, 1'b0);
      repeat (8) step(1'b0, 1'b1, '0, '1, 1'b1);
      glog.delete();

      // Fixed mode on channel 2, then no channel selected.
      for (int i = 0; i < N; i++) begin
         load(i, 1, 64'hF0 + 64'(i));
         load(i, 1, 64'hF4 + 64'(i));
         load(i, 1, 64'hF8 + 64'(i));
      end
      repeat (12) step(1'b0, 1'b0, 4'b0100, '1, 1'b1);
      check("fixed_count", 64'(glog.size()), 64'd3);
      for (int k = 0; k < 3; k++) check("fixed_grant", 64'(glog_at(k)), 64'd2);
      repeat (4) step(1'b0, 1'b0, 4'b0000, '1, 1'b1);
      clear_sources();
      glog.delete();

      // Round-robin resumes from the unchanged ptr; arb_enable drops mid-packet.
      load(1, 1, 64'h11);
      load(3, 4, 64'h30);
      repeat (4) step(1'b0, 1'b1, '0, '1, 1'b1);
      load(0, 1, 64'h40);
      load(2, 1, 64'h42);
      repeat (8) step(1'b0, 1'b0, 4'b0001, '1, 1'b1);
      check("mode_grant_0", 64'(glog_at(0)), 64'd1);
      check("mode_grant_1", 64'(glog_at(1)), 64'd3);
      check("mode_grant_2", 64'(glog_at(2)), 64'd0);
      repeat (4) step(1'b0, 1'b0, 4'b0000, '1, 1'b1);
      clear_sources();
      glog.delete();

      // Reset in the middle of a packet with ptr moved away from 0.
      load(2, 1, 64'h52);
      load(3, 5, 64'h60);
      repeat (5) step(1'b0, 1'b1, '0, '1, 1'b1);
      step(1'b1, 1'b1, '0, '1, 1'b1);
      glog.delete();
      load(0, 1, 64'h70);
      load(1, 1, 64'h71);
      load(3, 1, 64'h73);
      repeat (8) step(1'b0, 1'b1, '0, '1, 1'b1);
      check("post_rst_grant", 64'(glog_at(0)), 64'd0);
      glog.delete();

      // Randomized traffic.
      arb_r = 1'b1;
      sel_r = 4'b0001;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0) load_rand(i, $urandom_range(1, 4));
         end
         if ($urandom_range(0, 49) == 0) arb_r = ~arb_r;
         if ($urandom_range(0, 19) == 0) sel_r = ($urandom_range(0, 4) == 0) ? '0 : onehot($urandom_range(0, N - 1));
         for (int i = 0; i < N; i++) vm[i] = ($urandom_range(0, 4) != 0);
         step($urandom_range(0, 399) == 0, arb_r, sel_r, vm, $urandom_range(0, 3) != 0);
         glog.delete();
      end

      // Drain everything still queued upstream and in the output slot.
      repeat (100) step(1'b0, 1'b1, '0, '1, 1'b1);
      check("sb_leftover", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
